// File: rtl/demux3_buf.sv
// Three-way demultiplexer feeding per-destination FIFO buffers with valid/ready handshakes.
// A stalled consumer only backs up its own buffer; an accepted-beat counter is kept for debug.

module demux3_buf_lane #(
  parameter int N     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [N-1:0] wdata,
  input  logic         ready,
  output logic         full,
  output logic         valid,
  output logic [N-1:0] data
);
  localparam int AW = $clog2(DEPTH);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   occ;
  logic          pop;

  assign valid = (occ != '0);
  assign full  = (occ == (AW+1)'(DEPTH));
  assign pop   = valid & ready;
  assign data  = mem[rptr];

  // Storage is cleared on reset so the heads read as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end
endmodule

module demux3_buf #(
  parameter int N     = 8,
  parameter int DEPTH = 2,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  in_data,
  input  logic [1:0]    in_sel,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  out0_data,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [N-1:0]  out1_data,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [N-1:0]  out2_data,
  output logic          out2_valid,
  input  logic          out2_ready,
  output logic [CW-1:0] acc_cnt
);
  localparam int LANES = 3;

  logic [LANES-1:0]        sel_oh, push, full, valid, ready;
  logic [LANES-1:0][N-1:0] data;
  logic                    accept;

  // Same select encoding as the datapath mux: 1x both land on lane 2.
  always_comb begin
    sel_oh = 3'b100;
    if (in_sel == 2'b00)      sel_oh = 3'b001;
    else if (in_sel == 2'b01) sel_oh = 3'b010;
  end

  assign in_ready = |(sel_oh & ~full);
  assign accept   = in_valid & in_ready;
  assign push     = sel_oh & {LANES{accept}};
  assign ready    = {out2_ready, out1_ready, out0_ready};

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    demux3_buf_lane #(.N(N), .DEPTH(DEPTH)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .push  (push[g]),
      .wdata (in_data),
      .ready (ready[g]),
      .full  (full[g]),
      .valid (valid[g]),
      .data  (data[g])
    );
  end

  assign out0_data  = data[0];
  assign out1_data  = data[1];
  assign out2_data  = data[2];
  assign out0_valid = valid[0];
  assign out1_valid = valid[1];
  assign out2_valid = valid[2];

  always_ff @(posedge clk) begin
    if (rst)         acc_cnt <= '0;
    else if (accept) acc_cnt <= acc_cnt + 1'b1;
  end
endmodule

// File: tb/tb_demux3_buf.sv
// Bench for demux3_buf: directed scenarios plus a randomized run against per-output queues.
// CW is reduced so the counter wrap is reachable in a short run.

module tb_demux3_buf;
  localparam int N = 8, DEPTH = 2, CW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  in_data;
  logic [1:0]    in_sel;
  logic          in_valid, in_ready;
  logic [N-1:0]  out0_data, out1_data, out2_data;
  logic          out0_valid, out1_valid, out2_valid;
  logic [2:0]    rdy;
  logic [CW-1:0] acc_cnt;

  demux3_buf #(.N(N), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(rdy[0]),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(rdy[1]),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(rdy[2]),
    .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  logic [2:0]   vld;
  logic [N-1:0] dat [3];
  always_comb begin
    vld    = {out2_valid, out1_valid, out0_valid};
    dat[0] = out0_data;
    dat[1] = out1_data;
    dat[2] = out2_data;
  end

  int checks = 0, failures = 0;
  logic [N-1:0] q [3][$];
  int unsigned cnt = 0;
  bit last_acc;

  function automatic int dest(input logic [1:0] s);
    return (s == 2'b00) ? 0 : (s == 2'b01) ? 1 : 2;
  endfunction

  // Advance one clock and apply the same beat to the reference queues.
  task automatic tick();
    int d;
    bit acc;
    d   = dest(in_sel);
    acc = in_valid && (q[d].size() < DEPTH);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 3; i++) q[i].delete();
      cnt = 0;
      last_acc = 0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (rdy[i] && q[i].size() > 0) void'(q[i].pop_front());
      if (acc) begin
        q[d].push_back(in_data);
        cnt = (cnt + 1) % (1 << CW);
      end
      last_acc = acc;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 1; in_sel = 2'b00; in_data = 8'h5A; rdy = 3'b000;
    tick(); tick();
    checks++; if (vld !== 3'b000) begin failures++; $display("FAIL reset_valid got=%b exp=000", vld); end
    checks++; if (acc_cnt !== '0) begin failures++; $display("FAIL reset_acc got=%0d exp=0", acc_cnt); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (dat[i] !== '0) begin failures++; $display("FAIL reset_data%0d got=%h exp=00", i, dat[i]); end
    end
    rst = 0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    in_valid = 0;
  endtask

  task automatic test_routing();
    logic [N-1:0] b;
    rdy = 3'b111;
    for (int k = 0; k < 4; k++) begin
      b = N'((k + 1) * 8'h11);
      in_sel = 2'(k); in_data = b; in_valid = 1; #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL route_ready%0d got=%b exp=1", k, in_ready); end
      tick();
      checks++;
      if (vld[dest(2'(k))] !== 1'b1 || dat[dest(2'(k))] !== b) begin
        failures++; $display("FAIL route_beat%0d got=%b/%h exp=1/%h", k, vld[dest(2'(k))], dat[dest(2'(k))], b);
      end
    end
    in_valid = 0;
    checks++; if (acc_cnt !== CW'(4)) begin failures++; $display("FAIL route_acc got=%0d exp=4", acc_cnt); end
    tick();
    checks++; if (vld !== 3'b000) begin failures++; $display("FAIL route_drain got=%b exp=000", vld); end
  endtask

  task automatic test_backpressure();
    rdy = 3'b101; in_sel = 2'b01; in_valid = 1;
    in_data = 8'hA0; tick();
    in_data = 8'hA1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_second_ready got=%b exp=1", in_ready); end
    tick();
    in_data = 8'hA2; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
    tick();
    checks++; if (out1_data !== 8'hA0) begin failures++; $display("FAIL bp_head_stable got=%h exp=a0", out1_data); end
    in_sel = 2'b00; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_switch_ready got=%b exp=1", in_ready); end
    tick();
    checks++; if (!out0_valid || out0_data !== 8'hA2) begin failures++; $display("FAIL bp_out0 got=%b/%h exp=1/a2", out0_valid, out0_data); end
    in_valid = 0; rdy = 3'b111;
    checks++; if (!out1_valid || out1_data !== 8'hA0) begin failures++; $display("FAIL bp_rel0 got=%b/%h exp=1/a0", out1_valid, out1_data); end
    tick();
    checks++; if (!out1_valid || out1_data !== 8'hA1) begin failures++; $display("FAIL bp_rel1 got=%b/%h exp=1/a1", out1_valid, out1_data); end
    tick();
    checks++; if (vld !== 3'b000) begin failures++; $display("FAIL bp_drain got=%b exp=000", vld); end
  endtask

  task automatic test_full_nolookahead();
    rdy = 3'b000; in_sel = 2'b10; in_valid = 1;
    in_data = 8'hB0; tick();
    in_data = 8'hB1; tick();
    rdy = 3'b100; in_data = 8'hB2; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", in_ready); end
    tick();
    checks++; if (!out2_valid || out2_data !== 8'hB1) begin failures++; $display("FAIL full_head got=%b/%h exp=1/b1", out2_valid, out2_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_next_ready got=%b exp=1", in_ready); end
    tick();
    checks++; if (!out2_valid || out2_data !== 8'hB2) begin failures++; $display("FAIL full_push got=%b/%h exp=1/b2", out2_valid, out2_data); end
    in_valid = 0; tick();
    checks++; if (vld !== 3'b000) begin failures++; $display("FAIL full_drain got=%b exp=000", vld); end
  endtask

  task automatic test_push_pop();
    rdy = 3'b000; in_sel = 2'b00; in_valid = 1; in_data = 8'h55; tick();
    rdy = 3'b001; in_data = 8'h66; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL pp_ready got=%b exp=1", in_ready); end
    tick();
    checks++; if (!out0_valid || out0_data !== 8'h66) begin failures++; $display("FAIL pp_head got=%b/%h exp=1/66", out0_valid, out0_data); end
    in_valid = 0; tick();
    checks++; if (out0_valid !== 1'b0) begin failures++; $display("FAIL pp_occ got=%b exp=0", out0_valid); end
  endtask

  task automatic test_reset_wrap();
    int beats, cyc;
    rdy = 3'b000; in_valid = 1;
    for (int k = 0; k < 6; k++) begin
      in_sel = 2'(k / 2); in_data = 8'($urandom); tick();
    end
    checks++; if (vld !== 3'b111) begin failures++; $display("FAIL wrap_fill got=%b exp=111", vld); end
    rst = 1; tick(); rst = 0; in_valid = 0; rdy = 3'b111;
    checks++; if (vld !== 3'b000) begin failures++; $display("FAIL wrap_rst got=%b exp=000", vld); end
    tick();
    checks++; if (vld !== 3'b000) begin failures++; $display("FAIL wrap_no_old got=%b exp=000", vld); end
    beats = 0; cyc = 0;
    while (beats < (1 << CW) + 3 && cyc < 20000) begin
      in_data  = 8'($urandom);
      in_sel   = 2'($urandom);
      in_valid = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < 3; i++) rdy[i] = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (in_ready !== (q[dest(in_sel)].size() < DEPTH)) begin
        failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, in_ready, q[dest(in_sel)].size() < DEPTH);
      end
      tick();
      if (last_acc) beats++;
      cyc++;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (vld[i] !== (q[i].size() != 0) || (q[i].size() != 0 && dat[i] !== q[i][0])) begin
          failures++; $display("FAIL rnd_out%0d cyc=%0d got=%b/%h exp=%0d entries", i, cyc, vld[i], dat[i], q[i].size());
        end
      end
    end
    in_valid = 0;
    checks++; if (beats != (1 << CW) + 3) begin failures++; $display("FAIL rnd_budget got=%0d exp=%0d", beats, (1 << CW) + 3); end
    checks++; if (acc_cnt !== CW'(cnt) || cnt != 3) begin failures++; $display("FAIL rnd_acc got=%0d exp=3", acc_cnt); end
  endtask

  initial begin
    rst = 1; in_data = '0; in_sel = '0; in_valid = 0; rdy = '0;
    @(negedge clk);
    test_reset();
    test_routing();
    test_backpressure();
    test_full_nolookahead();
    test_push_pop();
    test_reset_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
